// File: rtl/conv_seq_unit_if.sv
// Window-in / result-out handshake bundle for conv_seq_unit.
// The master side offers windows and drains results; the slave side is the conv unit.
interface conv_seq_unit_if #(
  parameter int N = 18
);
  logic              in_valid;
  logic              in_ready;
  logic [N*16-1:0]   image;
  logic [N*16-1:0]   weight;
  logic [15:0]       bias;
  logic              relu_en;
  logic [15:0]       result;
  logic              cu_out_valid;
  logic              out_ready;

  modport master (
    output in_valid, image, weight, bias, relu_en, out_ready,
    input  in_ready, result, cu_out_valid
  );

  modport slave (
    input  in_valid, image, weight, bias, relu_en, out_ready,
    output in_ready, result, cu_out_valid
  );
endinterface

// File: rtl/conv_seq_unit.sv
// Sequential float16 convolution: lanes products per cycle, then bias and optional ReLU.
// Result valid N/lanes+2 cycles after accept and held until out_ready; one window in flight.
module conv_seq_unit #(
  parameter int data_width    = 16,
  parameter int input_channel = 2,
  parameter int weight_length = 3,
  parameter int weight_width  = 3,
  parameter int lanes         = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic conv_en,
  output logic busy,
  conv_seq_unit_if.slave bus
);

  localparam int W  = data_width;
  localparam int N  = input_channel * weight_length * weight_width;
  localparam int IW = $clog2(N + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - lanes);

  typedef enum logic [1:0] {IDLE, ACCUM, BIAS, OUT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N*W-1:0]  r_image;
  logic [N*W-1:0]  r_weight;
  logic [W-1:0]    r_bias;
  logic [W-1:0]    r_acc;
  logic [W-1:0]    r_result;
  logic            r_relu;
  logic            r_out_vld;
  logic [IW-1:0]   r_idx;

  logic            w_accept;
  logic            w_acc_step;
  logic            w_bias_step;
  logic            w_out_load;
  logic            w_out_done;
  logic [W-1:0]    w_grp;
  logic [W-1:0]    w_addend;
  logic [W-1:0]    w_sum;

  // binary16 multiply, RNE, subnormals flushed to signed zero
  function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    logic        sr;
    logic        a_z, b_z, a_inf, b_inf, a_nan, b_nan;
    logic [21:0] prod;
    logic [10:0] man;
    logic [11:0] mr;
    logic        g, st;
    int          e;
    logic [15:0] r;
    sr    = a[15] ^ b[15];
    a_z   = (a[14:10] == 5'h00);
    b_z   = (b[14:10] == 5'h00);
    a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
    b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
    a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
    b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
    prod  = '0;
    man   = '0;
    mr    = '0;
    g     = 1'b0;
    st    = 1'b0;
    e     = 0;
    r     = '0;
    if (a_nan || b_nan || (a_inf && b_z) || (b_inf && a_z)) begin
      r = 16'h7E00;
    end else if (a_inf || b_inf) begin
      r = {sr, 5'h1F, 10'h0};
    end else if (a_z || b_z) begin
      r = {sr, 15'h0};
    end else begin
      prod = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
      e    = int'(a[14:10]) + int'(b[14:10]) - 15;
      if (prod[21]) begin
        man = prod[21:11];
        g   = prod[10];
        st  = |prod[9:0];
        e   = e + 1;
      end else begin
        man = prod[20:10];
        g   = prod[9];
        st  = |prod[8:0];
      end
      mr = {1'b0, man} + 12'(g && (st || man[0]));
      if (mr[11]) begin
        mr = mr >> 1;
        e  = e + 1;
      end
      if (e >= 31)     r = {sr, 5'h1F, 10'h0};
      else if (e <= 0) r = {sr, 15'h0};
      else             r = {sr, e[4:0], mr[9:0]};
    end
    return r;
  endfunction

  // binary16 add with 3 extra bits (guard/round/sticky) below the mantissa
  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    logic        a_z, b_z, a_inf, b_inf, a_nan, b_nan;
    logic [15:0] x, y, r;
    logic [4:0]  d;
    logic [13:0] mx, my;
    logic [27:0] al;
    logic [14:0] s;
    logic [11:0] mr;
    int          e;
    a_z   = (a[14:10] == 5'h00);
    b_z   = (b[14:10] == 5'h00);
    a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
    b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
    a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
    b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
    x  = a;
    y  = b;
    r  = '0;
    d  = '0;
    mx = '0;
    my = '0;
    al = '0;
    s  = '0;
    mr = '0;
    e  = 0;
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
      r = 16'h7E00;
    end else if (a_inf) begin
      r = a;
    end else if (b_inf) begin
      r = b;
    end else if (a_z && b_z) begin
      r = {a[15] & b[15], 15'h0};
    end else if (a_z) begin
      r = b;
    end else if (b_z) begin
      r = a;
    end else begin
      if (a[14:0] < b[14:0]) begin
        x = b;
        y = a;
      end
      d  = x[14:10] - y[14:10];
      mx = {1'b1, x[9:0], 3'b000};
      my = {1'b1, y[9:0], 3'b000};
      al = {my, 14'h0} >> ((d > 5'd15) ? 5'd15 : d);
      my = al[27:14] | {13'h0, |al[13:0]};
      if (x[15] == y[15]) s = {1'b0, mx} + {1'b0, my};
      else                s = {1'b0, mx} - {1'b0, my};
      e = int'(x[14:10]);
      if (s == '0) begin
        r = 16'h0000;
      end else begin
        if (s[14]) begin
          s = {1'b0, s[14:2], |s[1:0]};
          e = e + 1;
        end else begin
          for (int i = 0; i < 13; i++) begin
            if (!s[13]) begin
              s = s << 1;
              e = e - 1;
            end
          end
        end
        mr = {1'b0, s[13:3]} + 12'(s[2] && ((|s[1:0]) || s[3]));
        if (mr[11]) begin
          mr = mr >> 1;
          e  = e + 1;
        end
        if (e >= 31)     r = {x[15], 5'h1F, 10'h0};
        else if (e <= 0) r = {x[15], 15'h0};
        else             r = {x[15], e[4:0], mr[9:0]};
      end
    end
    return r;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_acc_step  = 1'b0;
    w_bias_step = 1'b0;
    w_out_load  = 1'b0;
    w_out_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (conv_en) begin
          w_acc_step = 1'b1;
          if (r_idx == LAST_IDX) w_state_nxt = BIAS;
        end
      end
      BIAS: begin
        if (conv_en) begin
          w_bias_step = 1'b1;
          w_state_nxt = OUT;
        end
      end
      OUT: begin
        // first OUT cycle registers the result; valid is then held until taken
        if (!r_out_vld) begin
          w_out_load = 1'b1;
        end else if (bus.out_ready) begin
          w_out_done  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // the latched vectors shift left each step, so the current group is always the top lanes
  always_comb begin
    w_grp = fp_mul(r_image[N*W-1 -: W], r_weight[N*W-1 -: W]);
    for (int j = 1; j < lanes; j++) begin
      w_grp = fp_add(w_grp, fp_mul(r_image[(N-1-j)*W +: W], r_weight[(N-1-j)*W +: W]));
    end
    w_addend = (r_state == BIAS) ? r_bias : w_grp;
    w_sum    = fp_add(r_acc, w_addend);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_image   <= '0;
      r_weight  <= '0;
      r_bias    <= '0;
      r_relu    <= 1'b0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_result  <= '0;
      r_out_vld <= 1'b0;
    end else begin
      if (w_accept) begin
        r_image  <= bus.image;
        r_weight <= bus.weight;
        r_bias   <= bus.bias;
        r_relu   <= bus.relu_en;
        r_acc    <= '0;
        r_idx    <= '0;
      end
      if (w_acc_step) begin
        r_acc    <= w_sum;
        r_idx    <= r_idx + IW'(lanes);
        r_image  <= r_image << (lanes * W);
        r_weight <= r_weight << (lanes * W);
      end
      if (w_bias_step) r_acc <= w_sum;
      if (w_out_load) begin
        r_result  <= (r_relu && r_acc[W-1]) ? '0 : r_acc;
        r_out_vld <= 1'b1;
      end
      if (w_out_done) r_out_vld <= 1'b0;
    end
  end

  assign bus.in_ready     = (r_state == IDLE);
  assign bus.cu_out_valid = r_out_vld;
  assign bus.result       = r_result;
  assign busy             = (r_state != IDLE);

endmodule
